pull_to_push_adapter: RTL

PULL_TO_PUSH_ADAPTER -- requirements
Module: pull_to_push_adapter

---
 rtl/pull_to_push_adapter.sv | 95 +++++++++
 1 files changed

// File: rtl/pull_to_push_adapter.sv
// rtl/pull_to_push_adapter.sv - turns a req/ack pull interface into a valid/ready push stream
// A single outstanding pull request feeds a small FIFO that drains to the downstream consumer.
module pull_to_push_adapter #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    output logic                       req_o,
    input  logic                       ack_i,
    input  logic [DataWidth-1:0]       pull_data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth+1)-1:0] depth_o,
    output logic                       err_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthMax = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(Depth - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 armed_q;
    logic                 err_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 wr_en, rd_en;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Entering REQ only while count < Depth reserves the slot the ack will fill,
    // since the count cannot grow again until that ack lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && enable_i && (count_q < DepthMax)) state_d = REQ;
            REQ:     if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // armed_q holds off the first request until the second edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    assign req_o   = (state_q == REQ);
    assign wr_en   = (state_q == REQ) && ack_i;
    assign valid_o = (count_q != '0);
    assign rd_en   = valid_o && ready_i;
    assign depth_o = count_q;
    assign err_o   = err_q;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (rd_en) rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ack_i && (state_q == IDLE)) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed once count_q covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= pull_data_i;
    end

endmodule
